pll_lock_supervisor: RTL and testbench

Supervises the fabric PLL from the reference-clock side: it drives the PLL reset, watches the PLL `locked` output and releases the downstream clock-domain resets in order only after lock has been stable for a programmable time. On loss of lock it re-asserts all downstream resets immediately, counts the event and restarts the PLL. It sits between the PLL instance and the reset synchronizers of the `outclk_0`/`outclk_1` domains.

---
 rtl/pll_lock_supervisor.sv | 142 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// Purpose: sequences PLL reset and ordered release of two downstream domain resets once lock is qualified.
// Latency: pll_locked reaches the FSM after SYNC_STAGES edges; every output is registered one edge after its decision.
// Backpressure: none; free-running supervisor. Loss of lock re-asserts all resets on the very next edge.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int RELEASE_GAP    = 8,
    parameter int CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             rst_out_0,
    output logic             rst_out_1,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic             timeout_err
);

    // One shared phase counter serves every timed state, so size it for the longest interval.
    localparam int MAX_AB  = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CD  = (LOCK_TIMEOUT > RELEASE_GAP) ? LOCK_TIMEOUT : RELEASE_GAP;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_ALL + 1);

    // PLL_RST entered from another state starts at 1 so the entry cycle counts toward the hold;
    // after rst it starts at 0 because the hold is measured from the first un-reset edge.
    localparam logic [CW-1:0] PRST_DONE = CW'(PLL_RST_CYCLES);
    localparam logic [CW-1:0] LT_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SC_LAST   = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] RG_LAST   = CW'(RELEASE_GAP - 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_REL0,
        S_RUN
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;

    assign locked_s = sync[SYNC_STAGES-1];

    // Bring the asynchronous lock indicator into the refclk domain.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Supervisor FSM: restart PLL, wait for lock, qualify it, release resets in order, watch for loss.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= S_PLL_RST;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            rst_out_0     <= 1'b1;
            rst_out_1     <= 1'b1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (cnt == PRST_DONE) begin
                        state   <= S_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == LT_LAST) begin
                        state       <= S_PLL_RST;
                        cnt         <= CW'(1);
                        pll_rst     <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STABLE: begin
                    // A dropout here only restarts qualification; it is not a loss after release.
                    if (!locked_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == SC_LAST) begin
                        state     <= S_REL0;
                        cnt       <= '0;
                        rst_out_0 <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_REL0, S_RUN: begin
                    if (!locked_s) begin
                        state     <= S_PLL_RST;
                        cnt       <= CW'(1);
                        pll_rst   <= 1'b1;
                        rst_out_0 <= 1'b1;
                        rst_out_1 <= 1'b1;
                        ready     <= 1'b0;
                        if (lock_loss_cnt != '1) begin
                            lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
                        end
                    end else if (state == S_REL0) begin
                        if (cnt == RG_LAST) begin
                            state     <= S_RUN;
                            cnt       <= '0;
                            rst_out_1 <= 1'b0;
                            ready     <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state     <= S_PLL_RST;
                    cnt       <= CW'(1);
                    pll_rst   <= 1'b1;
                    rst_out_0 <= 1'b1;
                    rst_out_1 <= 1'b1;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: expected output vectors are queued against cycle numbers
// and compared on the falling edge; an ordering invariant is also checked every cycle.
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       rst_out_0;
    logic       rst_out_1;
    logic       ready;
    logic [1:0] lock_loss_cnt;
    logic       timeout_err;

    pll_lock_supervisor #(
        .SYNC_STAGES    (2),
        .PLL_RST_CYCLES (4),
        .STABLE_CYCLES  (16),
        .LOCK_TIMEOUT   (100),
        .RELEASE_GAP    (3),
        .CNT_W          (2)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .rst_out_0     (rst_out_0),
        .rst_out_1     (rst_out_1),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .timeout_err   (timeout_err)
    );

    // vector layout: {pll_rst, rst_out_0, rst_out_1, ready, timeout_err, lock_loss_cnt[1:0]}
    typedef struct packed {
        logic [31:0]  cyc;
        logic [127:0] tag;
        logic [6:0]   exp;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   edge_n      = 0;

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    always @(posedge refclk) edge_n <= edge_n + 1;

    task automatic expect_at(input int c, input logic [127:0] tag, input logic [6:0] v);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.exp = v;
        q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (edge_n < c) @(negedge refclk);
    endtask

    always @(negedge refclk) begin : mon
        logic [6:0] obs;
        obs = {pll_rst, rst_out_0, rst_out_1, ready, timeout_err, lock_loss_cnt};
        if (edge_n >= 1) begin
            vectors++;
            assert ((ready === !rst_out_1) && !(rst_out_0 === 1'b1 && rst_out_1 === 1'b0))
            else begin
                miscompares++;
                $error("FAIL invariant cyc=%0d observed=%b required ready==!rst_out_1 and rst_out_1 released after rst_out_0",
                       edge_n, obs);
            end
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == edge_n) begin
                vectors++;
                assert (obs === q[i].exp)
                else begin
                    miscompares++;
                    $error("FAIL %0s cyc=%0d observed=%b expected=%b", q[i].tag, edge_n, obs, q[i].exp);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        int t0;
        int t1;
        int r;
        int last;
        rst        = 1'b1;
        pll_locked = 1'b0;

        // reset held for two edges; cycle 0 is the first edge with rst low
        expect_at(2, "reset_hold", 7'b1110000);
        wait_until(2);
        rst = 1'b0;
        t0  = 3;

        // clean startup, lock at cycle 10, then a loss 50 cycles into RUN and a relock
        expect_at(t0 + 0,   "start_prst",   7'b1110000);
        expect_at(t0 + 3,   "prst_last",    7'b1110000);
        expect_at(t0 + 4,   "wait_lock",    7'b0110000);
        expect_at(t0 + 28,  "stable_hold",  7'b0110000);
        expect_at(t0 + 29,  "rel0",         7'b0010000);
        expect_at(t0 + 31,  "rel0_hold",    7'b0010000);
        expect_at(t0 + 32,  "run",          7'b0001000);
        expect_at(t0 + 84,  "run_pre_loss", 7'b0001000);
        expect_at(t0 + 85,  "loss1",        7'b1110001);
        expect_at(t0 + 88,  "loss1_prst",   7'b1110001);
        expect_at(t0 + 89,  "loss1_wait",   7'b0110001);
        expect_at(t0 + 113, "relock_hold",  7'b0110001);
        expect_at(t0 + 114, "relock_rel0",  7'b0010001);
        expect_at(t0 + 117, "relock_run",   7'b0001001);
        wait_until(t0 + 10);
        pll_locked = 1'b1;
        wait_until(t0 + 82);
        pll_locked = 1'b0;
        wait_until(t0 + 95);
        pll_locked = 1'b1;

        // second loss, two timeouts with no lock, then a one-cycle glitch during qualification
        expect_at(t0 + 132, "run_pre_loss2", 7'b0001001);
        expect_at(t0 + 133, "loss2",         7'b1110010);
        expect_at(t0 + 236, "to1_pre",       7'b0110010);
        expect_at(t0 + 237, "timeout1",      7'b1110110);
        expect_at(t0 + 240, "timeout_prst",  7'b1110110);
        expect_at(t0 + 241, "rewait",        7'b0110110);
        expect_at(t0 + 340, "to2_pre",       7'b0110110);
        expect_at(t0 + 341, "timeout2",      7'b1110110);
        expect_at(t0 + 364, "glitch_stable", 7'b0110110);
        expect_at(t0 + 365, "glitch_wait",   7'b0110110);
        expect_at(t0 + 369, "glitch_norel",  7'b0110110);
        expect_at(t0 + 381, "glitch_hold",   7'b0110110);
        expect_at(t0 + 382, "glitch_rel0",   7'b0010110);
        expect_at(t0 + 385, "glitch_run",    7'b0001110);
        wait_until(t0 + 130);
        pll_locked = 1'b0;
        wait_until(t0 + 350);
        pll_locked = 1'b1;
        wait_until(t0 + 362);
        pll_locked = 1'b0;
        wait_until(t0 + 363);
        pll_locked = 1'b1;

        // reset in RUN with count 2 and sticky flag set clears everything on the next edge
        wait_until(t0 + 390);
        rst = 1'b1;
        expect_at(t0 + 391, "midrst", 7'b1110000);
        wait_until(t0 + 391);
        rst = 1'b0;
        t1  = t0 + 392;
        expect_at(t1 + 3,  "rst2_prst", 7'b1110000);
        expect_at(t1 + 4,  "rst2_wait", 7'b0110000);
        expect_at(t1 + 21, "rst2_rel0", 7'b0010000);
        expect_at(t1 + 24, "rst2_run",  7'b0001000);

        // five losses after release: counter saturates at 3
        r = t1 + 24;
        for (int i = 0; i < 5; i++) begin
            int pi;
            int ni;
            pi = (i < 3) ? i : 3;
            ni = (i + 1 < 3) ? i + 1 : 3;
            expect_at(r + 7, "sat_pre",  {5'b00010, 2'(pi)});
            expect_at(r + 8, "sat_loss", {5'b11100, 2'(ni)});
            wait_until(r + 5);
            pll_locked = 1'b0;
            wait_until(r + 14);
            pll_locked = 1'b1;
            r = r + 36;
        end
        expect_at(r, "sat_run", 7'b0001011);
        last = r;

        wait_until(last + 5);
        while (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %0s never sampled cyc=%0d expected=%b", q[0].tag, q[0].cyc, q[0].exp);
            void'(q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
